vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/position timing generator with pixel clock-enable divider.
// Define VGA_TIMING_LOOKAHEAD_EN to add next_hcount/next_vcount/next_bright outputs.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int FW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          bright,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_count
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CW-1:0] next_hcount,
  output logic [CW-1:0] next_vcount,
  output logic          next_bright
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int XW = CW + 1;
  typedef logic [XW-1:0] ext_t;

  // Boundaries held one bit wider than the counters so totals of 2^CW do not overflow.
  localparam ext_t H_LAST = ext_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam ext_t H_VIS  = ext_t'(H_VISIBLE);
  localparam ext_t H_SS   = ext_t'(H_VISIBLE + H_FRONT);
  localparam ext_t H_SE   = ext_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam ext_t V_LAST = ext_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam ext_t V_VIS  = ext_t'(V_VISIBLE);
  localparam ext_t V_SS   = ext_t'(V_VISIBLE + V_FRONT);
  localparam ext_t V_SE   = ext_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          div_last;
  logic          ls_q;
  logic          fs_q;
  ext_t          h_ext;
  ext_t          v_ext;
  ext_t          h_nxt;
  ext_t          v_nxt;
  logic          h_wrap;

  function automatic logic is_visible(input ext_t h, input ext_t v);
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  always_comb begin
    h_ext  = {1'b0, hcount};
    v_ext  = {1'b0, vcount};
    h_wrap = (h_ext == H_LAST);
    h_nxt  = h_wrap ? '0 : h_ext + ext_t'(1);
    v_nxt  = v_ext;
    if (h_wrap) begin
      v_nxt = (v_ext == V_LAST) ? '0 : v_ext + ext_t'(1);
    end
  end

  assign div_last    = (div_q == DIV_LAST);
  assign pix_ce      = en & ~reset & div_last;
  // Pulses are held in registers but masked while stalled so a frozen cycle never shows one.
  assign line_start  = ls_q & en;
  assign frame_start = fs_q & en;

  // Sync/bright are computed from the incoming position so they align with hcount/vcount.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      hcount      <= H_LAST[CW-1:0];
      vcount      <= V_LAST[CW-1:0];
      frame_count <= '1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      bright      <= 1'b0;
      ls_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (en) begin
        div_q <= div_last ? '0 : div_q + DW'(1);
        if (div_last) begin
          hcount <= h_nxt[CW-1:0];
          vcount <= v_nxt[CW-1:0];
          hsync  <= ((h_nxt >= H_SS) && (h_nxt < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
          vsync  <= ((v_nxt >= V_SS) && (v_nxt < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
          bright <= is_visible(h_nxt, v_nxt);
          ls_q   <= (h_nxt == '0);
          fs_q   <= (h_nxt == '0) && (v_nxt == '0);
          if ((h_nxt == '0) && (v_nxt == '0)) begin
            frame_count <= frame_count + FW'(1);
          end
        end
      end
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  assign next_hcount = h_nxt[CW-1:0];
  assign next_vcount = v_nxt[CW-1:0];
  assign next_bright = is_visible(h_nxt, v_nxt);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against a pixel-index model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int DIV0 = 3;
  localparam int HV = 20, HF = 3, HS = 4, HB = 5;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  typedef struct packed {
    logic [4:0] h;
    logic [4:0] v;
    logic [2:0] f;
    logic       hs;
    logic       vs;
    logic       br;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       pix_ce0, hsync0, vsync0, bright0, line_start0, frame_start0;
  logic [4:0] hcount0, vcount0;
  logic [2:0] frame_count0;
  logic       pix_ce1, hsync1, vsync1, bright1, line_start1, frame_start1;
  logic [4:0] hcount1, vcount1;
  logic [2:0] frame_count1;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [4:0] next_hcount0, next_vcount0, next_hcount1, next_vcount1;
  logic       next_bright0, next_bright1;
`endif

  int  checks = 0;
  int  errors = 0;
  int  n_en = 0;
  bit  adv0 = 0;
  bit  adv1 = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(DIV0), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CW(5), .FW(3)
  ) dut0 (
    .clk(clk), .reset(reset), .en(en), .pix_ce(pix_ce0), .hsync(hsync0), .vsync(vsync0),
    .bright(bright0), .hcount(hcount0), .vcount(vcount0), .line_start(line_start0),
    .frame_start(frame_start0), .frame_count(frame_count0)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .next_hcount(next_hcount0), .next_vcount(next_vcount0), .next_bright(next_bright0)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(5), .FW(3)
  ) dut1 (
    .clk(clk), .reset(reset), .en(en), .pix_ce(pix_ce1), .hsync(hsync1), .vsync(vsync1),
    .bright(bright1), .hcount(hcount1), .vcount(vcount1), .line_start(line_start1),
    .frame_start(frame_start1), .frame_count(frame_count1)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .next_hcount(next_hcount1), .next_vcount(next_vcount1), .next_bright(next_bright1)
`endif
  );

  // Expected raster state after p pixel strobes since reset (p = 0 means reset values).
  function automatic exp_t model(input int p, input bit hpol, input bit vpol);
    exp_t e;
    int q, h, v;
    if (p == 0) begin
      e.h = 5'(HT - 1); e.v = 5'(VT - 1); e.f = 3'b111;
      e.hs = ~hpol; e.vs = ~vpol; e.br = 1'b0;
      return e;
    end
    q = p - 1;
    h = q % HT;
    v = (q / HT) % VT;
    e.h  = 5'(h);
    e.v  = 5'(v);
    e.f  = 3'((q / (HT * VT)) % 8);
    e.hs = (h >= HV + HF && h < HV + HF + HS) ? hpol : ~hpol;
    e.vs = (v >= VV + VF && v < VV + VF + VS) ? vpol : ~vpol;
    e.br = (h < HV) && (v < VV);
    return e;
  endfunction

  // One clock: drive inputs at negedge, compare all outputs, then advance the model at posedge.
  task automatic cycle(input bit en_v, input bit rst_v);
    exp_t e0, e1;
    bit   live, xp0, xls0, xfs0, xfs1;
    @(negedge clk);
    en = en_v;
    reset = rst_v;
    if (rst_v) begin n_en = 0; adv0 = 0; adv1 = 0; end
    #1;
    e0 = model(n_en / DIV0, 1'b0, 1'b1);
    e1 = model(n_en, 1'b1, 1'b0);
    live = en_v && !rst_v;
    xp0  = live && (n_en % DIV0 == DIV0 - 1);
    xls0 = live && adv0 && (e0.h == 0);
    xfs0 = xls0 && (e0.v == 0);
    xfs1 = live && adv1 && (e1.h == 0) && (e1.v == 0);
    checks += 15;
    if (pix_ce0 !== xp0) begin errors++; $display("FAIL pix_ce0: got %b exp %b n=%0d", pix_ce0, xp0, n_en); end
    if (hcount0 !== e0.h) begin errors++; $display("FAIL hcount0: got %0d exp %0d", hcount0, e0.h); end
    if (vcount0 !== e0.v) begin errors++; $display("FAIL vcount0: got %0d exp %0d", vcount0, e0.v); end
    if (frame_count0 !== e0.f) begin errors++; $display("FAIL frame_count0: got %0d exp %0d", frame_count0, e0.f); end
    if (hsync0 !== e0.hs) begin errors++; $display("FAIL hsync0: got %b exp %b h=%0d", hsync0, e0.hs, e0.h); end
    if (vsync0 !== e0.vs) begin errors++; $display("FAIL vsync0: got %b exp %b v=%0d", vsync0, e0.vs, e0.v); end
    if (bright0 !== e0.br) begin errors++; $display("FAIL bright0: got %b exp %b", bright0, e0.br); end
    if (line_start0 !== xls0) begin errors++; $display("FAIL line_start0: got %b exp %b", line_start0, xls0); end
    if (frame_start0 !== xfs0) begin errors++; $display("FAIL frame_start0: got %b exp %b", frame_start0, xfs0); end
    if (pix_ce1 !== live) begin errors++; $display("FAIL pix_ce1: got %b exp %b", pix_ce1, live); end
    if (hcount1 !== e1.h) begin errors++; $display("FAIL hcount1: got %0d exp %0d", hcount1, e1.h); end
    if (vcount1 !== e1.v) begin errors++; $display("FAIL vcount1: got %0d exp %0d", vcount1, e1.v); end
    if (hsync1 !== e1.hs) begin errors++; $display("FAIL hsync1: got %b exp %b h=%0d", hsync1, e1.hs, e1.h); end
    if (bright1 !== e1.br) begin errors++; $display("FAIL bright1: got %b exp %b", bright1, e1.br); end
    if (frame_start1 !== xfs1) begin errors++; $display("FAIL frame_start1: got %b exp %b", frame_start1, xfs1); end
`ifdef VGA_TIMING_LOOKAHEAD_EN
    e0 = model(n_en / DIV0 + 1, 1'b0, 1'b1);
    checks += 3;
    if (next_hcount0 !== e0.h) begin errors++; $display("FAIL next_hcount0: got %0d exp %0d", next_hcount0, e0.h); end
    if (next_vcount0 !== e0.v) begin errors++; $display("FAIL next_vcount0: got %0d exp %0d", next_vcount0, e0.v); end
    if (next_bright0 !== e0.br) begin errors++; $display("FAIL next_bright0: got %b exp %b", next_bright0, e0.br); end
`endif
    @(posedge clk);
    if (reset) begin
      n_en = 0; adv0 = 0; adv1 = 0;
    end else begin
      adv0 = en && (n_en % DIV0 == DIV0 - 1);
      adv1 = en;
      if (en) n_en++;
    end
  endtask

  task automatic goto_pos(input int h, input int v, output bit found);
    found = 0;
    for (int i = 0; i < 4 * HT * VT * DIV0 && !found; i++) begin
      cycle(1'b1, 1'b0);
      #1;
      if (hcount0 == 5'(h) && vcount0 == 5'(v)) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL goto_pos: position %0d,%0d not reached", h, v); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    #1;
    checks += 6;
    if (hcount0 !== 5'd31) begin errors++; $display("FAIL rst_hcount: got %0d exp 31", hcount0); end
    if (vcount0 !== 5'd18) begin errors++; $display("FAIL rst_vcount: got %0d exp 18", vcount0); end
    if (frame_count0 !== 3'd7) begin errors++; $display("FAIL rst_frame_count: got %0d exp 7", frame_count0); end
    if (pix_ce1 !== 1'b0) begin errors++; $display("FAIL rst_pix_ce1: got %b exp 0", pix_ce1); end
    if (hsync1 !== 1'b0) begin errors++; $display("FAIL rst_hsync1: got %b exp 0", hsync1); end
    if (bright0 !== 1'b0) begin errors++; $display("FAIL rst_bright0: got %b exp 0", bright0); end
  endtask

  task automatic test_first_pixel();
    for (int i = 0; i < DIV0; i++) cycle(1'b1, 1'b0);
    #1;
    checks += 6;
    if (hcount0 !== 5'd0) begin errors++; $display("FAIL first_hcount: got %0d exp 0", hcount0); end
    if (vcount0 !== 5'd0) begin errors++; $display("FAIL first_vcount: got %0d exp 0", vcount0); end
    if (frame_start0 !== 1'b1) begin errors++; $display("FAIL first_frame_start: got %b exp 1", frame_start0); end
    if (line_start0 !== 1'b1) begin errors++; $display("FAIL first_line_start: got %b exp 1", line_start0); end
    if (frame_count0 !== 3'd0) begin errors++; $display("FAIL first_frame_count: got %0d exp 0", frame_count0); end
    if (hcount1 !== 5'd2) begin errors++; $display("FAIL first_hcount1: got %0d exp 2", hcount1); end
  endtask

  task automatic test_random_run();
    for (int i = 0; i < 20000; i++) cycle($urandom_range(9) != 0, 1'b0);
  endtask

  task automatic test_en_freeze();
    bit found;
    bit moved;
    goto_pos(HV - 1, VV - 1, found);
    for (int i = 0; i < 37; i++) cycle(1'b0, 1'b0);
    #1;
    checks += 3;
    if (hcount0 !== 5'(HV - 1)) begin errors++; $display("FAIL freeze_hcount: got %0d exp %0d", hcount0, HV - 1); end
    if (bright0 !== 1'b1) begin errors++; $display("FAIL freeze_bright: got %b exp 1", bright0); end
    if (pix_ce1 !== 1'b0) begin errors++; $display("FAIL freeze_pix_ce1: got %b exp 0", pix_ce1); end
    moved = 0;
    for (int i = 0; i < DIV0 + 1 && !moved; i++) begin
      cycle(1'b1, 1'b0);
      #1;
      if (hcount0 != 5'(HV - 1)) moved = 1;
    end
    checks += 2;
    if (hcount0 !== 5'(HV)) begin errors++; $display("FAIL resume_hcount: got %0d exp %0d", hcount0, HV); end
    if (bright0 !== 1'b0) begin errors++; $display("FAIL resume_bright: got %b exp 0", bright0); end
  endtask

  task automatic test_reset_midframe();
    bit found;
    goto_pos(10, 6, found);
    @(negedge clk);
    reset = 1'b1;
    n_en = 0; adv0 = 0; adv1 = 0;
    #1;
    checks += 4;
    if (bright0 !== 1'b0) begin errors++; $display("FAIL mid_rst_bright: got %b exp 0", bright0); end
    if (hsync0 !== 1'b1) begin errors++; $display("FAIL mid_rst_hsync0: got %b exp 1", hsync0); end
    if (vsync0 !== 1'b0) begin errors++; $display("FAIL mid_rst_vsync0: got %b exp 0", vsync0); end
    if (hcount0 !== 5'd31) begin errors++; $display("FAIL mid_rst_hcount: got %0d exp 31", hcount0); end
    cycle(1'b1, 1'b1);
    for (int i = 0; i < DIV0; i++) cycle(1'b1, 1'b0);
    #1;
    checks += 3;
    if (frame_start0 !== 1'b1) begin errors++; $display("FAIL mid_frame_start: got %b exp 1", frame_start0); end
    if (frame_count0 !== 3'd0) begin errors++; $display("FAIL mid_frame_count: got %0d exp 0", frame_count0); end
    if (hcount0 !== 5'd0) begin errors++; $display("FAIL mid_hcount: got %0d exp 0", hcount0); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_random_run();
    test_en_freeze();
    test_reset_midframe();
    for (int i = 0; i < 200; i++) cycle($urandom_range(3) != 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
